// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fpu_pkg                                                    |
// | Description : Shared types and constants for the single-precision FPU    |
// |               blocks (divider, rounding stage, later fsqrt).             |
// |               float_t   : packed IEEE-754 single view {sign, exp, frac}  |
// |               state     : 2-bit encoded divider FSM states               |
// |               is_zero / is_inf : operand class helpers (FTZ, no NaN)     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package fpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } float_t;

   localparam int          EXP_BIAS  = 127;
   localparam int          EXP_MAX   = 255;
   localparam logic [31:0] POS_INF   = 32'h7F80_0000;
   localparam int          QUOT_BITS = 26;

   // Divider FSM encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DIV   = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // Denormals are flushed, so any zero exponent counts as zero.
   function automatic logic is_zero(input float_t f);
      return (f.exp == 8'h00);
   endfunction

   // Mantissa is ignored for exponent 255: everything there is infinity.
   function automatic logic is_inf(input float_t f);
      return (f.exp == 8'hFF);
   endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fdiv_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fdiv_round                                                 |
// | Description : Combinational normalize / round-to-nearest-even /          |
// |               exponent range check for a 26-bit restoring quotient.      |
// |   sign    in  1   result sign                                            |
// |   exp_in  in  10  signed biased exponent, e1 - e2 + 127                  |
// |   quot    in  26  quotient, bit 25 or bit 24 is the leading one          |
// |   rem_nz  in  1   final partial remainder is non-zero                    |
// |   y       out 32  packed single result                                   |
// |   ovf     out 1   result saturated to infinity                           |
// |   unf     out 1   result flushed to zero                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fdiv_round
   import fpu_pkg::*;
(
   input  logic                 sign,
   input  logic signed [9:0]    exp_in,
   input  logic [QUOT_BITS-1:0] quot,
   input  logic                 rem_nz,
   output logic [31:0]          y,
   output logic                 ovf,
   output logic                 unf
);

   logic [22:0]       w_frac;
   logic              w_guard;
   logic              w_sticky;
   logic              w_round_up;
   logic [23:0]       w_sum;
   logic signed [9:0] w_exp_norm;
   logic signed [9:0] w_exp_rnd;
   logic [22:0]       w_frac_rnd;

   always_comb begin
      // Quotient lies in [2^24, 2^26): the leading one selects the window.
      if (quot[25]) begin
         w_frac     = quot[24:2];
         w_guard    = quot[1];
         w_sticky   = quot[0] | rem_nz;
         w_exp_norm = exp_in;
      end else begin
         w_frac     = quot[23:1];
         w_guard    = quot[0];
         w_sticky   = rem_nz;
         w_exp_norm = exp_in - 10'sd1;
      end

      w_round_up = w_guard & (w_sticky | w_frac[0]);
      w_sum      = {1'b0, w_frac} + {23'd0, w_round_up};

      // Carry out of the fraction bumps the exponent; fraction wraps to 0.
      if (w_sum[23]) begin
         w_exp_rnd  = w_exp_norm + 10'sd1;
         w_frac_rnd = 23'd0;
      end else begin
         w_exp_rnd  = w_exp_norm;
         w_frac_rnd = w_sum[22:0];
      end

      ovf = 1'b0;
      unf = 1'b0;
      if (w_exp_rnd >= 10'(EXP_MAX)) begin
         y   = {sign, POS_INF[30:0]};
         ovf = 1'b1;
      end else if (w_exp_rnd <= 10'sd0) begin
         y   = {sign, 31'd0};
         unf = 1'b1;
      end else begin
         y   = {sign, w_exp_rnd[7:0], w_frac_rnd};
      end
   end

endmodule : fdiv_round
`default_nettype wire

// File: rtl/fdiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fdiv_iter                                                  |
// | Description : Iterative IEEE-754 single divider y = x1 / x2 with a       |
// |               constant latency of 26/BITS_PER_CYCLE + 2 cycles.          |
// |   clk    in  1   clock, rising edge                                      |
// |   rst    in  1   synchronous active-high reset                           |
// |   start  in  1   request, accepted only in IDLE                          |
// |   x1     in  32  dividend                                                |
// |   x2     in  32  divisor                                                 |
// |   busy   out 1   operation in flight (DIV, ROUND, DONE)                  |
// |   done   out 1   one-cycle result strobe                                 |
// |   y      out 32  quotient, held until the next done                      |
// |   ovf    out 1   exponent overflow                                       |
// |   unf    out 1   exponent underflow, flushed to zero                     |
// |   dz     out 1   divide by zero                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fdiv_iter
   import fpu_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        busy,
   output logic        done,
   output logic [31:0] y,
   output logic        ovf,
   output logic        unf,
   output logic        dz
);

   // Only 1 and 2 are supported; anything else falls back to 1.
   localparam int         BPC        = (BITS_PER_CYCLE == 2) ? 2 : 1;
   localparam int         DIV_CYCLES = QUOT_BITS / BPC;
   localparam logic [4:0] LAST_CNT   = 5'(DIV_CYCLES - 1);

   logic [1:0]           state_q,    state_d;
   logic [4:0]           cnt_q,      cnt_d;
   logic [24:0]          rem_q,      rem_d;
   logic [QUOT_BITS-1:0] quot_q,     quot_d;
   logic [23:0]          div_q,      div_d;
   logic                 sign_q,     sign_d;
   logic signed [9:0]    exp_q,      exp_d;
   logic                 spec_q,     spec_d;
   logic                 spec_inf_q, spec_inf_d;
   logic                 spec_dz_q,  spec_dz_d;
   logic [31:0]          y_q,        y_d;
   logic                 ovf_q,      ovf_d;
   logic                 unf_q,      unf_d;
   logic                 dz_q,       dz_d;

   float_t               w_a;
   float_t               w_b;
   logic [24:0]          w_rem;
   logic [QUOT_BITS-1:0] w_quot;
   logic [25:0]          w_diff;
   logic [31:0]          w_rnd_y;
   logic                 w_rnd_ovf;
   logic                 w_rnd_unf;

   assign w_a = float_t'(x1);
   assign w_b = float_t'(x2);

   fdiv_round u_round (
      .sign   (sign_q),
      .exp_in (exp_q),
      .quot   (quot_q),
      .rem_nz (|rem_q),
      .y      (w_rnd_y),
      .ovf    (w_rnd_ovf),
      .unf    (w_rnd_unf)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      div_d      = div_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      spec_d     = spec_q;
      spec_inf_d = spec_inf_q;
      spec_dz_d  = spec_dz_q;
      y_d        = y_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      dz_d       = dz_q;
      w_rem      = rem_q;
      w_quot     = quot_q;
      w_diff     = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = DIV;
               cnt_d      = 5'd0;
               rem_d      = {1'b0, 1'b1, w_a.frac};
               div_d      = {1'b1, w_b.frac};
               quot_d     = '0;
               sign_d     = w_a.sign ^ w_b.sign;
               exp_d      = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                            + 10'(EXP_BIAS);
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
               dz_d       = 1'b0;
               spec_inf_d = 1'b0;
               spec_dz_d  = 1'b0;
               spec_d     = 1'b1;
               // Priority matters: a zero divisor wins over every dividend,
               // then a zero dividend wins over an infinite divisor.
               if (is_zero(w_b)) begin
                  spec_inf_d = 1'b1;
                  spec_dz_d  = 1'b1;
               end else if (is_zero(w_a)) begin
                  spec_inf_d = 1'b0;
               end else if (is_inf(w_a)) begin
                  spec_inf_d = 1'b1;
               end else if (is_inf(w_b)) begin
                  spec_inf_d = 1'b0;
               end else begin
                  spec_d     = 1'b0;
               end
            end
         end

         DIV: begin
            // Special operands still iterate so latency never depends on data.
            // The remainder is kept below 2*divisor, so 25 bits never overflow.
            for (int i = 0; i < BPC; i++) begin
               w_diff = {1'b0, w_rem} - {2'b00, div_q};
               if (!w_diff[25]) begin
                  w_rem = w_diff[24:0];
               end
               w_quot = {w_quot[QUOT_BITS-2:0], ~w_diff[25]};
               w_rem  = {w_rem[23:0], 1'b0};
            end
            rem_d  = w_rem;
            quot_d = w_quot;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = ROUND;
            end
         end

         ROUND: begin
            state_d = DONE;
            if (spec_q) begin
               y_d   = spec_inf_q ? {sign_q, POS_INF[30:0]} : {sign_q, 31'd0};
               dz_d  = spec_dz_q;
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end else begin
               y_d   = w_rnd_y;
               ovf_d = w_rnd_ovf;
               unf_d = w_rnd_unf;
               dz_d  = 1'b0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         rem_q      <= '0;
         quot_q     <= '0;
         div_q      <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         spec_q     <= 1'b0;
         spec_inf_q <= 1'b0;
         spec_dz_q  <= 1'b0;
         y_q        <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         dz_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         div_q      <= div_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         spec_q     <= spec_d;
         spec_inf_q <= spec_inf_d;
         spec_dz_q  <= spec_dz_d;
         y_q        <= y_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         dz_q       <= dz_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign y    = y_q;
   assign ovf  = ovf_q;
   assign unf  = unf_q;
   assign dz   = dz_q;

endmodule : fdiv_iter
`default_nettype wire

// File: tb/tb_fdiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fdiv_iter                                               |
// | Description : Self-checking bench for fdiv_iter. Two instances           |
// |               (1 and 2 quotient bits per cycle) share the stimulus and   |
// |               are compared with an integer-arithmetic reference model.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fdiv_iter;

   localparam int L1     = 28;
   localparam int L2     = 15;
   localparam int N_RAND = 1500;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] x1, x2;
   logic        busy1, done1, ovf1, unf1, dz1;
   logic        busy2, done2, ovf2, unf2, dz2;
   logic [31:0] y1, y2;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   int          q1t[$], q2t[$];
   logic [34:0] q1v[$], q2v[$];
   int          nb1, nb2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fdiv_iter #(.BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2),
      .busy(busy1), .done(done1), .y(y1), .ovf(ovf1), .unf(unf1), .dz(dz1)
   );

   fdiv_iter #(.BITS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2),
      .busy(busy2), .done(done2), .y(y2), .ovf(ovf2), .unf(unf2), .dz(dz2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, unf, dz, y}, computed with exact integer division.
   function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      int     ea, eb, e;
      longint mx, my, num, q, r, m, low, half;
      logic   up;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0)   return {3'b001, s, 8'hFF, 23'd0};
      if (ea == 0)   return {3'b000, s, 31'd0};
      if (ea == 255) return {3'b000, s, 8'hFF, 23'd0};
      if (eb == 255) return {3'b000, s, 31'd0};
      mx  = longint'({1'b1, a[22:0]});
      my  = longint'({1'b1, b[22:0]});
      num = mx * 33554432;               // mx * 2^25
      q   = num / my;
      r   = num % my;
      if (q >= 33554432) begin
         m = q / 4; low = q % 4; half = 2; e = ea - eb + 127;
      end else begin
         m = q / 2; low = q % 2; half = 1; e = ea - eb + 126;
      end
      // Nearest-even: above half rounds up, exact half rounds to even.
      up = (low > half) || (low == half && r != 0) || (low == half && r == 0 && (m % 2) == 1);
      if (up) m = m + 1;
      if (m >= 16777216) begin
         m = m / 2;
         e = e + 1;
      end
      if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
      if (e <= 0)   return {3'b010, s, 31'd0};
      return {3'b000, s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      int          k;
      v = $urandom;
      k = int'($urandom_range(0, 19));
      if (k == 0)      v[30:23] = 8'h00;
      else if (k == 1) v[30:23] = 8'hFF;
      else             v[30:23] = 8'($urandom_range(1, 254));
      return v;
   endfunction

   task automatic clear_obs();
      q1t.delete(); q2t.delete(); q1v.delete(); q2v.delete();
      nb1 = 0; nb2 = 0;
   endtask

   // Sample outputs on falling edges, logging done events and busy cycles.
   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done1) begin q1t.push_back(cyc); q1v.push_back({ovf1, unf1, dz1, y1}); end
         if (done2) begin q2t.push_back(cyc); q2v.push_back({ovf2, unf2, dz2, y2}); end
         if (busy1) nb1++;
         if (busy2) nb2++;
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, output int ks);
      x1 = a; x2 = b; start = 1'b1;
      @(posedge clk);
      #1;
      ks = cyc;
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] expv, input bit inject);
      int ks;
      clear_obs();
      issue(a, b, ks);
      if (inject) begin
         watch(4);
         x1 = ~a; x2 = b ^ 32'h0040_0000; start = 1'b1;
         watch(1);
         start = 1'b0; x1 = a; x2 = b;
         watch(24);
      end else begin
         watch(29);
      end
      check_eq({tag, "/ndone1"}, 64'(q1t.size()), 64'd1);
      check_eq({tag, "/ndone2"}, 64'(q2t.size()), 64'd1);
      check_eq({tag, "/lat1"}, (q1t.size() > 0) ? 64'(q1t[0] - ks + 1) : 64'd0, 64'(L1));
      check_eq({tag, "/lat2"}, (q2t.size() > 0) ? 64'(q2t[0] - ks + 1) : 64'd0, 64'(L2));
      check_eq({tag, "/res1"}, (q1v.size() > 0) ? 64'(q1v[0]) : '1, 64'(expv));
      check_eq({tag, "/res2"}, (q2v.size() > 0) ? 64'(q2v[0]) : '1, 64'(expv));
      check_eq({tag, "/busy1"}, 64'(nb1), 64'(L1));
      check_eq({tag, "/busy2"}, 64'(nb2), 64'(L2));
   endtask

   initial begin
      int          ks;
      logic [31:0] ra, rb;

      rst = 1'b1; start = 1'b0; x1 = '0; x2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset1", {busy1, done1, ovf1, unf1, dz1, y1}, 64'd0);
      check_eq("reset2", {busy2, done2, ovf2, unf2, dz2, y2}, 64'd0);
      rst = 1'b0;
      watch(2);

      run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, {3'b000, 32'h4040_0000}, 1'b0);
      run_op("one_third",  32'h3F80_0000, 32'h4040_0000, {3'b000, 32'h3EAA_AAAB}, 1'b0);
      run_op("neg_six",    32'hC0C0_0000, 32'h4000_0000, {3'b000, 32'hC040_0000}, 1'b0);
      run_op("div_zero",   32'h3F80_0000, 32'h0000_0000, {3'b001, 32'h7F80_0000}, 1'b0);
      run_op("zero_num",   32'h0000_0000, 32'h4000_0000, {3'b000, 32'h0000_0000}, 1'b0);
      run_op("overflow",   32'h7F00_0000, 32'h0080_0000, {3'b100, 32'h7F80_0000}, 1'b0);
      run_op("underflow",  32'h0080_0000, 32'h7F00_0000, {3'b010, 32'h0000_0000}, 1'b0);
      run_op("inf_inf",    32'h7F80_0000, 32'hFF80_0000, {3'b000, 32'hFF80_0000}, 1'b0);
      run_op("fin_inf",    32'h4000_0000, 32'h7F80_0000, {3'b000, 32'h0000_0000}, 1'b0);
      run_op("start_busy", 32'h40C0_0000, 32'h4000_0000, {3'b000, 32'h4040_0000}, 1'b1);

      // Start held high across DONE: second op accepted right after DONE.
      clear_obs();
      x1 = 32'h3F80_0000; x2 = 32'h4040_0000; start = 1'b1;
      @(posedge clk);
      #1;
      ks = cyc;
      x1 = 32'hC0C0_0000; x2 = 32'h4000_0000;
      watch(57);
      start = 1'b0;
      watch(40);
      check_eq("hold/ndone1", 64'(q1t.size()), 64'd2);
      check_eq("hold/lat1", (q1t.size() > 0) ? 64'(q1t[0] - ks + 1) : 64'd0, 64'(L1));
      check_eq("hold/gap1", (q1t.size() > 1) ? 64'(q1t[1] - q1t[0]) : 64'd0, 64'(L1 + 1));
      check_eq("hold/gap2", (q2t.size() > 1) ? 64'(q2t[1] - q2t[0]) : 64'd0, 64'(L2 + 1));
      check_eq("hold/res1a", (q1v.size() > 0) ? 64'(q1v[0]) : '1, {3'b000, 32'h3EAA_AAAB});
      check_eq("hold/res1b", (q1v.size() > 1) ? 64'(q1v[1]) : '1, {3'b000, 32'hC040_0000});
      check_eq("hold/res2b", (q2v.size() > 1) ? 64'(q2v[1]) : '1, {3'b000, 32'hC040_0000});

      // Reset in the tenth cycle of an op abandons it.
      clear_obs();
      issue(32'h40C0_0000, 32'h4000_0000, ks);
      watch(9);
      rst = 1'b1;
      watch(1);
      check_eq("rst_mid1", {busy1, done1, ovf1, unf1, dz1, y1}, 64'd0);
      check_eq("rst_mid2", {busy2, done2, ovf2, unf2, dz2, y2}, 64'd0);
      rst = 1'b0;
      clear_obs();
      watch(40);
      check_eq("rst_nodone1", 64'(q1t.size()), 64'd0);
      check_eq("rst_nodone2", 64'(q2t.size()), 64'd0);
      run_op("after_rst", 32'h3F80_0000, 32'h4040_0000, {3'b000, 32'h3EAA_AAAB}, 1'b0);

      for (int n = 0; n < N_RAND; n++) begin
         ra = rand_fp();
         rb = rand_fp();
         if ($urandom_range(0, 9) == 0) rb[22:0] = ra[22:0];
         run_op("rand", ra, rb, ref_div(ra, rb), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fdiv_iter
`default_nettype wire
